// File: rtl/sum_accum_defs.sv
// Shared definitions for the sum accumulator: FSM state encodings and default widths.
package sum_accum_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 33;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/sum_accum_ctrl.sv
// Job controller: IDLE/ACCUM/DONE sequencing, beat counter, and beat/last/clear strobes.
module sum_accum_ctrl
  import sum_accum_defs::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_in_valid,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_beat,
  output logic             o_last,
  output logic             o_clear
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_beat;
  logic             w_last;
  logic             w_clear;

  // r_in_ready is high exactly in ACCUM, so a beat can only occur there
  assign w_beat  = r_in_ready && i_in_valid;
  assign w_last  = w_beat && (r_cnt == CNT_W'(1));
  assign w_clear = (r_state == ST_IDLE) && i_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_len != '0) begin
              r_cnt      <= i_len;
              r_in_ready <= 1'b1;
              r_state    <= ST_ACCUM;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_beat      = w_beat;
  assign o_last      = w_last;
  assign o_clear     = w_clear;

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates LEN unsigned adder results into a wide total with a sticky overflow flag.
module sum_accumulator
  import sum_accum_defs::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_beat;
  logic             w_last;
  logic             w_clear;

  function automatic logic [ACC_W:0] zext(input logic [IN_W-1:0] v);
    return {{(ACC_W + 1 - IN_W){1'b0}}, v};
  endfunction

  sum_accum_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_len       (len),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_beat      (w_beat),
    .o_last      (w_last),
    .o_clear     (w_clear)
  );

  // Extra top bit of the add is the carry out of the accumulator width
  assign w_sum = {1'b0, r_acc} + zext(in_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  assign out_total = r_acc;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 40-bit and a 34-bit instance driven in lockstep.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [32:0] in_sum;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [39:0] out_total_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [33:0] out_total_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.IN_W(33), .ACC_W(40), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_total(out_total_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  sum_accumulator #(.IN_W(33), .ACC_W(34), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_total(out_total_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  typedef struct {
    int               n;
    logic [3:0][32:0] sums;
    logic [39:0]      tot40;
    logic             ovf40;
    logic [33:0]      tot34;
    logic             ovf34;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " out_valid after handshake"}, {63'd0, out_valid_a}, 64'd0);
    chk({nm, " busy after handshake"}, {63'd0, busy_a}, 64'd0);
  endtask

  task automatic run_job(input string nm, input int n, input logic [3:0][32:0] s,
                         input logic [39:0] t40, input logic o40,
                         input logic [33:0] t34, input logic o34);
    start = 1'b1;
    len   = n[7:0];
    tick();
    start = 1'b0;
    if (n != 0) begin
      chk({nm, " in_ready in ACCUM"}, {63'd0, in_ready_a}, 64'd1);
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b1;
        in_sum   = s[i];
        tick();
        if (i < n - 1) chk({nm, " out_valid early"}, {63'd0, out_valid_a}, 64'd0);
      end
      in_valid = 1'b0;
    end
    chk({nm, " out_valid"}, {63'd0, out_valid_a}, 64'd1);
    chk({nm, " busy"}, {63'd0, busy_a}, 64'd1);
    chk({nm, " total40"}, {24'd0, out_total_a}, {24'd0, t40});
    chk({nm, " ovf40"}, {63'd0, out_ovf_a}, {63'd0, o40});
    chk({nm, " total34"}, {30'd0, out_total_b}, {30'd0, t34});
    chk({nm, " ovf34"}, {63'd0, out_ovf_b}, {63'd0, o34});
    handshake(nm);
  endtask

  initial begin
    vecs[0] = '{2, {33'h0, 33'h0, 33'h1_00000002, 33'h0_fffffffe},
                40'h02_0000_0000, 1'b0, 34'h2_0000_0000, 1'b0};
    vecs[1] = '{1, {33'h0, 33'h0, 33'h0, 33'h0_00000005},
                40'h00_0000_0005, 1'b0, 34'h0_0000_0005, 1'b0};
    vecs[2] = '{3, {33'h0, 33'h1_ffffffff, 33'h1_ffffffff, 33'h1_ffffffff},
                40'h05_ffff_fffd, 1'b0, 34'h1_ffff_fffd, 1'b1};
    vecs[3] = '{4, {33'h1_00000000, 33'h1_00000000, 33'h1_00000000, 33'h1_00000000},
                40'h04_0000_0000, 1'b0, 34'h0_0000_0000, 1'b1};
    vecs[4] = '{2, {33'h0, 33'h0, 33'h0_00000002, 33'h0_00000001},
                40'h00_0000_0003, 1'b0, 34'h0_0000_0003, 1'b0};

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset in_ready", {63'd0, in_ready_a}, 64'd0);
    chk("reset out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("reset total", {24'd0, out_total_a}, 64'd0);
    chk("reset ovf", {63'd0, out_ovf_a}, 64'd0);
    chk("reset busy", {63'd0, busy_a}, 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++)
      run_job($sformatf("vec%0d", v), vecs[v].n, vecs[v].sums,
              vecs[v].tot40, vecs[v].ovf40, vecs[v].tot34, vecs[v].ovf34);

    // Gapped input: block must wait with in_ready high
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap in_ready", {63'd0, in_ready_a}, 64'd1);
      chk("gap out_valid", {63'd0, out_valid_a}, 64'd0);
    end
    in_valid = 1'b1; in_sum = 33'h1_00000000;
    tick();
    in_valid = 1'b0;
    chk("gap out_valid", {63'd0, out_valid_a}, 64'd1);
    chk("gap total", {24'd0, out_total_a}, 64'h01_0000_0000);
    handshake("gap");

    // Zero-length job, held output
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0 out_valid", {63'd0, out_valid_a}, 64'd1);
    chk("len0 in_ready", {63'd0, in_ready_a}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("len0 hold valid", {63'd0, out_valid_a}, 64'd1);
      chk("len0 hold total", {24'd0, out_total_a}, 64'd0);
      chk("len0 hold ovf", {63'd0, out_ovf_a}, 64'd0);
    end
    handshake("len0");

    // Async reset mid-job
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_sum = 33'h0_00000007;
    tick();
    in_valid = 1'b0;
    chk("midjob total before rst", {24'd0, out_total_a}, 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("rst in_ready", {63'd0, in_ready_a}, 64'd0);
    chk("rst total", {24'd0, out_total_a}, 64'd0);
    chk("rst busy", {63'd0, busy_a}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid_a}, 64'd0);
    rst = 1'b0;
    tick();
    run_job("after rst", 1, {33'h0, 33'h0, 33'h0, 33'h0_00000005},
            40'h5, 1'b0, 34'h5, 1'b0);

    // start ignored in ACCUM and DONE; in_valid ignored outside ACCUM
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_sum = 33'h1;
    tick();
    in_valid = 1'b0; start = 1'b1; len = 8'd9;
    tick();
    start = 1'b0;
    chk("ign accum in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("ign accum total", {24'd0, out_total_a}, 64'd1);
    in_valid = 1'b1; in_sum = 33'h2;
    tick();
    chk("ign accum out_valid", {63'd0, out_valid_a}, 64'd1);
    chk("ign accum result", {24'd0, out_total_a}, 64'd3);
    start = 1'b1; len = 8'd0; in_valid = 1'b1; in_sum = 33'h1_23456789;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("ign done out_valid", {63'd0, out_valid_a}, 64'd1);
    chk("ign done total", {24'd0, out_total_a}, 64'd3);
    chk("ign done in_ready", {63'd0, in_ready_a}, 64'd0);
    handshake("ign");

    // Back-to-back: start in the first IDLE cycle after the handshake
    run_job("b2b", 1, {33'h0, 33'h0, 33'h0, 33'h0_00000004}, 40'h4, 1'b0, 34'h4, 1'b0);
    run_job("b2b2", 2, {33'h0, 33'h0, 33'h0_00000010, 33'h0_00000020},
            40'h30, 1'b0, 34'h30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
